// File: rtl/rom_arbiter_pkg.sv
// Shared types, constants and state helpers for the ROM/SRAM port arbiter.
package rom_arb_pkg;

    localparam int unsigned ACC_W = 4;
    localparam logic [ACC_W-1:0] CNT_ZERO = {ACC_W{1'b0}};
    localparam logic [ACC_W-1:0] CNT_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SNES_RD = 3'd1,
        SNES_WR = 3'd2,
        MCU_RD  = 3'd3,
        MCU_WR  = 3'd4
    } arb_state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_kind_e;

    function automatic arb_state_e access_state(input logic is_snes, input req_kind_e kind);
        arb_state_e st;
        if (is_snes) begin
            st = (kind == REQ_WR) ? SNES_WR : SNES_RD;
        end else begin
            st = (kind == REQ_WR) ? MCU_WR : MCU_RD;
        end
        return st;
    endfunction

    function automatic logic is_read_state(input arb_state_e st);
        logic r;
        case (st)
            SNES_RD, MCU_RD: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_write_state(input arb_state_e st);
        logic r;
        case (st)
            SNES_WR, MCU_WR: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_mcu_state(input arb_state_e st);
        logic r;
        case (st)
            MCU_RD, MCU_WR: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// SNES-side, MCU-side and memory-pin signals of rom_arbiter.
interface rom_arbiter_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              SNES_RD_START;
    logic              SNES_WR_START;
    logic [ADDR_W-1:0] SNES_ROM_ADDR;
    logic              SNES_ROM_HIT;
    logic              SNES_IS_WRITABLE;
    logic [7:0]        SNES_DOUT;
    logic [7:0]        SNES_DIN;
    logic              SNES_DATA_VALID;
    logic              MCU_RRQ;
    logic              MCU_WRQ;
    logic [ADDR_W-1:0] MCU_ADDR;
    logic [7:0]        MCU_DOUT;
    logic [7:0]        MCU_DIN;
    logic              MCU_RDY;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic [7:0]        ROM_DOUT;
    logic [7:0]        ROM_DIN;
    logic              ROM_OE_N;
    logic              ROM_WE_N;

    modport slave (
        input  SNES_RD_START, SNES_WR_START, SNES_ROM_ADDR, SNES_ROM_HIT,
               SNES_IS_WRITABLE, SNES_DOUT, MCU_RRQ, MCU_WRQ, MCU_ADDR,
               MCU_DOUT, ROM_DIN,
        output SNES_DIN, SNES_DATA_VALID, MCU_DIN, MCU_RDY, ROM_ADDR,
               ROM_DOUT, ROM_OE_N, ROM_WE_N
    );

    modport master (
        output SNES_RD_START, SNES_WR_START, SNES_ROM_ADDR, SNES_ROM_HIT,
               SNES_IS_WRITABLE, SNES_DOUT, MCU_RRQ, MCU_WRQ, MCU_ADDR,
               MCU_DOUT, ROM_DIN,
        input  SNES_DIN, SNES_DATA_VALID, MCU_DIN, MCU_RDY, ROM_ADDR,
               ROM_DOUT, ROM_OE_N, ROM_WE_N
    );
endinterface

// File: rtl/rom_arbiter_timer.sv
// Access-length timer: loaded with ACC_CYC-1 on grant, flags the final access cycle at zero.
module rom_arb_timer
    import rom_arb_pkg::*;
#(
    parameter int unsigned ACC_CYC = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic load_i,
    output logic last_o
);

    logic [ACC_W-1:0] cnt_q;
    logic [ACC_W-1:0] cnt_d;

    // Load on grant, then count down to zero and hold there.
    always_comb begin
        if (load_i) begin
            cnt_d = ACC_W'(ACC_CYC - 32'd1);
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/rom_arbiter.sv
// Time-shares one ROM/SRAM port between SNES and MCU accesses, SNES first.
// Optional: define WRITE_PROTECT_EN to drop SNES writes to non-writable regions.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ACC_CYC = 4,
    parameter int unsigned ADDR_W  = 24
) (
    input  logic         CLK,
    input  logic         RST,
    rom_arbiter_if.slave bus
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic timer_last_s;
    logic last_s;
    logic can_grant_s;
    logic grant_snes_s;
    logic grant_mcu_s;
    logic wr_ok_s;

    logic              snes_new_s;
    logic              snes_req_s;
    req_kind_e         snes_kind_new_s;
    req_kind_e         snes_kind_s;
    logic [ADDR_W-1:0] snes_addr_s;
    logic [7:0]        snes_data_s;
    logic              mcu_new_s;
    logic              mcu_req_s;
    req_kind_e         mcu_kind_new_s;
    req_kind_e         mcu_kind_s;
    logic [ADDR_W-1:0] mcu_addr_s;
    logic [7:0]        mcu_data_s;

    logic              snes_pend_q, snes_pend_d;
    req_kind_e         snes_kind_q, snes_kind_d;
    logic [ADDR_W-1:0] snes_addr_q, snes_addr_d;
    logic [7:0]        snes_data_q, snes_data_d;
    logic              mcu_pend_q,  mcu_pend_d;
    req_kind_e         mcu_kind_q,  mcu_kind_d;
    logic [ADDR_W-1:0] mcu_addr_q,  mcu_addr_d;
    logic [7:0]        mcu_data_q,  mcu_data_d;

    logic [ADDR_W-1:0] rom_addr_q,   rom_addr_d;
    logic [7:0]        rom_dout_q,   rom_dout_d;
    logic              rom_oe_n_q,   rom_oe_n_d;
    logic              rom_we_n_q,   rom_we_n_d;
    logic [7:0]        snes_din_q,   snes_din_d;
    logic              snes_valid_q, snes_valid_d;
    logic [7:0]        mcu_din_q,    mcu_din_d;
    logic              mcu_rdy_q,    mcu_rdy_d;

`ifdef WRITE_PROTECT_EN
    assign wr_ok_s = bus.SNES_IS_WRITABLE;
`else
    // Writability is deliberately ignored without protection.
    assign wr_ok_s = bus.SNES_IS_WRITABLE || 1'b1;
`endif

    rom_arb_timer #(
        .ACC_CYC (ACC_CYC)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .load_i (grant_snes_s || grant_mcu_s),
        .last_o (timer_last_s)
    );

    assign last_s      = timer_last_s && (state_q != IDLE);
    assign can_grant_s = (state_q == IDLE) || last_s;

    // Decode incoming requests; a fresh pulse overrides the pending entry.
    always_comb begin
        snes_kind_new_s = bus.SNES_WR_START ? REQ_WR : REQ_RD;
        snes_new_s = bus.SNES_ROM_HIT && (bus.SNES_RD_START || bus.SNES_WR_START)
                     && (!bus.SNES_WR_START || wr_ok_s);
        snes_req_s = snes_new_s || snes_pend_q;
        if (snes_new_s) begin
            snes_kind_s = snes_kind_new_s;
            snes_addr_s = bus.SNES_ROM_ADDR;
            snes_data_s = bus.SNES_DOUT;
        end else begin
            snes_kind_s = snes_kind_q;
            snes_addr_s = snes_addr_q;
            snes_data_s = snes_data_q;
        end
        mcu_kind_new_s = bus.MCU_WRQ ? REQ_WR : REQ_RD;
        mcu_new_s = (bus.MCU_RRQ || bus.MCU_WRQ) && mcu_rdy_q;
        // mcu_pend stays set while in service, so exclude the running access.
        mcu_req_s = mcu_new_s || (mcu_pend_q && !is_mcu_state(state_q));
        if (mcu_new_s) begin
            mcu_kind_s = mcu_kind_new_s;
            mcu_addr_s = bus.MCU_ADDR;
            mcu_data_s = bus.MCU_DOUT;
        end else begin
            mcu_kind_s = mcu_kind_q;
            mcu_addr_s = mcu_addr_q;
            mcu_data_s = mcu_data_q;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grants happen from IDLE or straight out of a final access cycle.
    always_comb begin
        state_d      = state_q;
        grant_snes_s = 1'b0;
        grant_mcu_s  = 1'b0;
        if (can_grant_s) begin
            if (snes_req_s) begin
                state_d      = access_state(1'b1, snes_kind_s);
                grant_snes_s = 1'b1;
            end else if (mcu_req_s) begin
                state_d     = access_state(1'b0, mcu_kind_s);
                grant_mcu_s = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Output values for the next cycle: bus load on grant, strobes, completion data.
    always_comb begin
        if (grant_snes_s) begin
            rom_addr_d = snes_addr_s;
            rom_dout_d = snes_data_s;
        end else if (grant_mcu_s) begin
            rom_addr_d = mcu_addr_s;
            rom_dout_d = mcu_data_s;
        end else begin
            rom_addr_d = rom_addr_q;
            rom_dout_d = rom_dout_q;
        end
        rom_oe_n_d   = !is_read_state(state_d);
        rom_we_n_d   = !is_write_state(state_d);
        snes_din_d   = snes_din_q;
        snes_valid_d = 1'b0;
        mcu_din_d    = mcu_din_q;
        if (last_s && (state_q == SNES_RD)) begin
            snes_din_d   = bus.ROM_DIN;
            snes_valid_d = 1'b1;
        end else if (last_s && (state_q == MCU_RD)) begin
            mcu_din_d = bus.ROM_DIN;
        end else begin
            snes_din_d = snes_din_q;
        end
        if (mcu_new_s) begin
            mcu_rdy_d = 1'b0;
        end else if (last_s && is_mcu_state(state_q)) begin
            mcu_rdy_d = 1'b1;
        end else begin
            mcu_rdy_d = mcu_rdy_q;
        end
    end

    // Pending request bookkeeping.
    always_comb begin
        snes_pend_d = snes_pend_q;
        snes_kind_d = snes_kind_q;
        snes_addr_d = snes_addr_q;
        snes_data_d = snes_data_q;
        if (grant_snes_s) begin
            snes_pend_d = 1'b0;
        end else if (snes_new_s) begin
            snes_pend_d = 1'b1;
            snes_kind_d = snes_kind_new_s;
            snes_addr_d = bus.SNES_ROM_ADDR;
            snes_data_d = bus.SNES_DOUT;
        end else begin
            snes_pend_d = snes_pend_q;
        end
        mcu_pend_d = mcu_pend_q;
        mcu_kind_d = mcu_kind_q;
        mcu_addr_d = mcu_addr_q;
        mcu_data_d = mcu_data_q;
        if (mcu_new_s) begin
            mcu_pend_d = 1'b1;
            mcu_kind_d = mcu_kind_new_s;
            mcu_addr_d = bus.MCU_ADDR;
            mcu_data_d = bus.MCU_DOUT;
        end else if (last_s && is_mcu_state(state_q)) begin
            mcu_pend_d = 1'b0;
        end else begin
            mcu_pend_d = mcu_pend_q;
        end
    end

    // Datapath, pending and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            snes_pend_q  <= 1'b0;
            snes_kind_q  <= REQ_RD;
            snes_addr_q  <= {ADDR_W{1'b0}};
            snes_data_q  <= 8'h00;
            mcu_pend_q   <= 1'b0;
            mcu_kind_q   <= REQ_RD;
            mcu_addr_q   <= {ADDR_W{1'b0}};
            mcu_data_q   <= 8'h00;
            rom_addr_q   <= {ADDR_W{1'b0}};
            rom_dout_q   <= 8'h00;
            rom_oe_n_q   <= 1'b1;
            rom_we_n_q   <= 1'b1;
            snes_din_q   <= 8'h00;
            snes_valid_q <= 1'b0;
            mcu_din_q    <= 8'h00;
            mcu_rdy_q    <= 1'b1;
        end else begin
            snes_pend_q  <= snes_pend_d;
            snes_kind_q  <= snes_kind_d;
            snes_addr_q  <= snes_addr_d;
            snes_data_q  <= snes_data_d;
            mcu_pend_q   <= mcu_pend_d;
            mcu_kind_q   <= mcu_kind_d;
            mcu_addr_q   <= mcu_addr_d;
            mcu_data_q   <= mcu_data_d;
            rom_addr_q   <= rom_addr_d;
            rom_dout_q   <= rom_dout_d;
            rom_oe_n_q   <= rom_oe_n_d;
            rom_we_n_q   <= rom_we_n_d;
            snes_din_q   <= snes_din_d;
            snes_valid_q <= snes_valid_d;
            mcu_din_q    <= mcu_din_d;
            mcu_rdy_q    <= mcu_rdy_d;
        end
    end

    assign bus.ROM_ADDR        = rom_addr_q;
    assign bus.ROM_DOUT        = rom_dout_q;
    assign bus.ROM_OE_N        = rom_oe_n_q;
    assign bus.ROM_WE_N        = rom_we_n_q;
    assign bus.SNES_DIN        = snes_din_q;
    assign bus.SNES_DATA_VALID = snes_valid_q;
    assign bus.MCU_DIN         = mcu_din_q;
    assign bus.MCU_RDY         = mcu_rdy_q;

endmodule
